fetch_ctrl: RTL and testbench

//  Fetch sequencer owning the architectural PC of the single-issue core.

---
 rtl/fetch_ctrl_pkg.sv | 14 +
 rtl/fetch_pc_next.sv | 21 ++
 rtl/fetch_ctrl.sv | 109 ++++++++++
 tb/tb_fetch_ctrl.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/fetch_ctrl_pkg.sv
// Shared definitions for the fetch sequencer: widths, reset PC, FSM encoding.
package fetch_ctrl_pkg;

    localparam int          DEF_XLEN     = 32;
    localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] INST_NOP     = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_REQ  = 2'd0,
        ST_WAIT = 2'd1,
        ST_HOLD = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_pc_next.sv
// Next fetch PC: word-aligned redirect target wins, otherwise pc+4 when advancing.
module fetch_pc_next #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] pc,
    input  logic            advance,
    input  logic            redir_valid,
    input  logic [XLEN-1:0] redir_pc,
    output logic [XLEN-1:0] pc_next
);

    // The add wraps modulo 2^XLEN, so 0xFFFF_FFFC advances to 0.
    always_comb begin
        pc_next = pc;
        if (redir_valid)
            pc_next = {redir_pc[XLEN-1:2], 2'b00};
        else if (advance)
            pc_next = pc + XLEN'(4);
    end

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: one outstanding imem request, hands words to decode,
// applies execute redirects and drops responses they make stale.
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter int              XLEN     = DEF_XLEN,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(DEF_RESET_PC)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            halt,
    input  logic            redir_valid,
    input  logic [XLEN-1:0] redir_pc,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [31:0]     inst_data,
    output logic [XLEN-1:0] inst_pc
);

    fetch_state_t    state;
    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] pc_next;
    logic            drop;
    logic            req_valid;
    logic [XLEN-1:0] req_addr;
    logic            advance;

    assign advance        = (state == ST_HOLD) && inst_ready;
    assign imem_req_valid = req_valid;
    assign imem_req_addr  = req_addr;

    fetch_pc_next #(.XLEN(XLEN)) u_pc_next (
        .pc          (fetch_pc),
        .advance     (advance),
        .redir_valid (redir_valid),
        .redir_pc    (redir_pc),
        .pc_next     (pc_next)
    );

    // Any path back into REQ raises the next request immediately (unless halted),
    // so the address register always comes from pc_next, never the stale fetch_pc.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_REQ;
            fetch_pc   <= RESET_PC;
            drop       <= 1'b0;
            req_valid  <= 1'b0;
            req_addr   <= '0;
            inst_valid <= 1'b0;
            inst_data  <= '0;
            inst_pc    <= '0;
        end else begin
            fetch_pc <= pc_next;
            case (state)
                ST_REQ: begin
                    if (req_valid) begin
                        // A raised request stays put until accepted; a redirect only marks it stale.
                        if (redir_valid)
                            drop <= 1'b1;
                        if (imem_req_ready) begin
                            req_valid <= 1'b0;
                            state     <= ST_WAIT;
                        end
                    end else begin
                        req_valid <= !halt;
                        req_addr  <= pc_next;
                    end
                end
                ST_WAIT: begin
                    if (imem_rsp_valid) begin
                        if (drop || redir_valid) begin
                            drop      <= 1'b0;
                            state     <= ST_REQ;
                            req_valid <= !halt;
                            req_addr  <= pc_next;
                        end else begin
                            inst_valid <= 1'b1;
                            inst_data  <= imem_rsp_data;
                            inst_pc    <= fetch_pc;
                            state      <= ST_HOLD;
                        end
                    end else if (redir_valid) begin
                        drop <= 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (redir_valid || inst_ready) begin
                        inst_valid <= 1'b0;
                        if (redir_valid)
                            inst_data <= INST_NOP;
                        state     <= ST_REQ;
                        req_valid <= !halt;
                        req_addr  <= pc_next;
                    end
                end
                default: begin
                    state     <= ST_REQ;
                    req_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: handshakes, stalls, redirects, wrap, halt, reset.
module tb_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        halt = 1'b0;
    logic        redir_valid = 1'b0;
    logic [31:0] redir_pc = '0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;

    int errors = 0;
    int checks = 0;

    fetch_ctrl dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .halt           (halt),
        .redir_valid    (redir_valid),
        .redir_pc       (redir_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_data      (inst_data),
        .inst_pc        (inst_pc)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Full fetch: optional accept stall, response latency, decode consume, next request.
    task automatic do_fetch(input logic [31:0] addr, input int stall, input int lat,
                            input logic [31:0] word);
        for (int i = 0; i < 20 && !imem_req_valid; i++) tick();
        chk("req_raised", 32'(imem_req_valid), 32'd1);
        chk("req_addr", imem_req_addr, addr);
        imem_req_ready = 1'b0;
        for (int i = 0; i < stall; i++) begin
            tick();
            chk("stall_valid", 32'(imem_req_valid), 32'd1);
            chk("stall_addr", imem_req_addr, addr);
        end
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        chk("req_dropped_after_accept", 32'(imem_req_valid), 32'd0);
        for (int i = 1; i < lat; i++) tick();
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = word;
        tick();
        imem_rsp_valid = 1'b0;
        chk("inst_valid", 32'(inst_valid), 32'd1);
        chk("inst_pc", inst_pc, addr);
        chk("inst_data", inst_data, word);
        inst_ready = 1'b1;
        tick();
        inst_ready = 1'b0;
        chk("inst_consumed", 32'(inst_valid), 32'd0);
        chk("next_req_valid", 32'(imem_req_valid), 32'(!halt));
        if (!halt) chk("next_req_addr", imem_req_addr, addr + 32'd4);
    endtask

    // Accept the currently raised request and leave the FSM waiting for its response.
    task automatic accept_req(input logic [31:0] addr);
        chk("acc_addr", imem_req_addr, addr);
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
    endtask

    initial begin
        // Reset state
        #2 rst_n = 1'b0;
        #1;
        chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
        chk("rst_inst_valid", 32'(inst_valid), 32'd0);
        tick();
        chk("rst_inst_data", inst_data, 32'd0);
        chk("rst_inst_pc", inst_pc, 32'd0);
        rst_n = 1'b1;
        chk("rst_release_no_req", 32'(imem_req_valid), 32'd0);
        tick();

        // Sequential fetches, including a 3-cycle accept stall on 0x4
        do_fetch(32'h0, 0, 1, 32'hAAAA_0001);
        do_fetch(32'h4, 3, 1, 32'hAAAA_0002);

        // Redirect while waiting on 0x8: its response never reaches decode
        accept_req(32'h8);
        redir_valid = 1'b1; redir_pc = 32'h100;
        tick();
        redir_valid = 1'b0;
        chk("t3_wait_no_req", 32'(imem_req_valid), 32'd0);
        imem_rsp_valid = 1'b1; imem_rsp_data = 32'hDEAD_0008;
        tick();
        imem_rsp_valid = 1'b0;
        chk("t3_no_inst", 32'(inst_valid), 32'd0);
        chk("t3_req_valid", 32'(imem_req_valid), 32'd1);
        do_fetch(32'h100, 0, 2, 32'hAAAA_0100);

        // Redirect to 0x203 while holding 0x104 with inst_ready=1: word flushed
        accept_req(32'h104);
        imem_rsp_valid = 1'b1; imem_rsp_data = 32'hAAAA_0104;
        tick();
        imem_rsp_valid = 1'b0;
        chk("t4_hold", 32'(inst_valid), 32'd1);
        inst_ready = 1'b1; redir_valid = 1'b1; redir_pc = 32'h203;
        tick();
        inst_ready = 1'b0; redir_valid = 1'b0;
        chk("t4_flushed", 32'(inst_valid), 32'd0);
        do_fetch(32'h200, 0, 1, 32'hAAAA_0200);

        // Redirect while a raised request is stalled: request stays, response dropped
        chk("t4b_raised", imem_req_addr, 32'h204);
        redir_valid = 1'b1; redir_pc = 32'h300;
        tick();
        redir_valid = 1'b0;
        chk("t4b_stable_valid", 32'(imem_req_valid), 32'd1);
        accept_req(32'h204);
        imem_rsp_valid = 1'b1; imem_rsp_data = 32'hDEAD_0204;
        tick();
        imem_rsp_valid = 1'b0;
        chk("t4b_no_inst", 32'(inst_valid), 32'd0);
        do_fetch(32'h300, 0, 3, 32'hAAAA_0300);

        // Wrap: redirect (misaligned) to top of memory, next address wraps to 0
        accept_req(32'h304);
        redir_valid = 1'b1; redir_pc = 32'hFFFF_FFFE;
        tick();
        redir_valid = 1'b0;
        imem_rsp_valid = 1'b1; imem_rsp_data = 32'hDEAD_0304;
        tick();
        imem_rsp_valid = 1'b0;
        chk("t5_no_inst", 32'(inst_valid), 32'd0);
        do_fetch(32'hFFFF_FFFC, 0, 1, 32'hAAAA_FFFC);

        // halt: ignored for a raised request, blocks the next one
        halt = 1'b1;
        tick();
        chk("halt_raised_kept", 32'(imem_req_valid), 32'd1);
        do_fetch(32'h0, 0, 1, 32'hAAAA_0000);
        tick();
        chk("halt_no_req", 32'(imem_req_valid), 32'd0);
        halt = 1'b0;
        tick();
        chk("unhalt_req", 32'(imem_req_valid), 32'd1);
        chk("unhalt_addr", imem_req_addr, 32'h4);

        // Async reset mid-WAIT, late response afterwards ignored
        accept_req(32'h4);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_req_cleared", 32'(imem_req_valid), 32'd0);
        chk("t6_inst_cleared", 32'(inst_valid), 32'd0);
        tick();
        rst_n = 1'b1;
        imem_rsp_valid = 1'b1; imem_rsp_data = 32'hDEAD_0004;
        tick();
        imem_rsp_valid = 1'b0;
        chk("t6_late_rsp_ignored", 32'(inst_valid), 32'd0);
        do_fetch(32'h0, 1, 1, 32'hAAAA_1000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
